note_scroll: RTL and testbench
==============================

# note_scroll

Play-field engine for the guitar game; sits directly downstream of the difficulty selector. It consumes the selected scroll period (`diff_speed`) and `level`, and generates falling notes in a LANES×ROWS grid. The grid advances one row every `diff_speed` clocks, and lane presses are judged against the bottom row. It drives the grid to the display stage and hit/miss pulses and counts to the scoring stage.

## Interface
- `LANES`, 4, number of note lanes (≤4)
- `ROWS`, 8, grid depth; row 0 top, row ROWS-1 bottom (strike row)
- `PLAY_MODE`, 3'd2, `mode` encoding in which the field runs
- `clk`  in  1  system clock
- `rst`  in  1  reset; **one clock; reset is synchronous and active-high**
- `mode`  in  3  current game mode from mode FSM
- `diff_speed`  in  23  clocks per row step (from difficulty selector)
- `level`  in  2  1=EASY, 2=MEDIUM, 3=HARD; 0 treated as EASY
- `lane_press`  in  LANES  single-cycle, already-synchronised press pulses
- `grid`  out  LANES*ROWS  note bits; bit `r*LANES+l` = row r, lane l
- `step`  out  1  one-cycle pulse, grid just advanced
- `hit`  out  1  one-cycle pulse, ≥1 note struck this cycle
- `miss`  out  1  one-cycle pulse, ≥1 note fell off bottom this cycle
- `hit_count`  out  8  saturating hit total
- `miss_count`  out  8  saturating miss total

## Operation
- `run = (mode == PLAY_MODE)`; `run_d` = registered `run`; entry = `run & ~run_d`.
- Tick counter `cnt[22:0]`:
  - Held at 0 when `!run`.
  - Otherwise, `term = (cnt >= eff-1)` with `eff = (diff_speed==0) ? 1 : diff_speed`.
  - On `term`: `cnt <= 0`. Else `cnt <= cnt+1`.
  - `>=` compare: a `diff_speed` decrease mid-count wraps on the next cycle, with no long run-out.
- LFSR `lfsr[7:0]`:
  - Reset value 8'h01.
  - On `term`: `lfsr <= {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}`.
  - Never all-zero.
- New top row, computed from the pre-advance `lfsr`:
  - EASY: `lfsr[3:0]` if `lfsr[7:6]==2'b11`, else 0.
  - MEDIUM: `lfsr[3:0]` if `lfsr[7]`, else 0.
  - HARD: `lfsr[3:0]` always.
  - Masked to LANES bits in all cases.
- Strike judging, each `run` cycle:
  - `hitv = lane_press & bottom_row` (pre-update grid).
  - Struck bits are cleared from the bottom row.
  - A press on an empty lane is ignored; it is not a miss.
- Advance on `term`:
  - `missv = bottom_row & ~hitv` — notes leaving the grid un-struck.
  - Rows shift down one; the new top row enters at row 0.
- Same-cycle press and `term`: the press is judged against the pre-shift bottom row. A struck note is not counted as missed.
- Counts:
  - `hit_count += popcount(hitv)`.
  - `miss_count += popcount(missv)`.
  - Both saturate at 255.
- On entry (first `run` cycle): `grid`, `hit_count`, `miss_count` cleared to 0. `lfsr` keeps its value, so successive songs differ. Presses in the entry cycle are ignored.
- `!run`: `grid`, counts and `lfsr` hold; presses ignored; no `step`/`hit`/`miss`.

## Timing
- Reset values:
  - `grid` = 0
  - `step` = 0, `hit` = 0, `miss` = 0
  - `hit_count` = 0, `miss_count` = 0
  - `cnt` = 0, `lfsr` = 8'h01, `run_d` = 0
- All outputs are registered.
- `grid`, counts, `hit`, `miss` and `step` update at the same clock edge as the `term`/press that caused them. The pulses are high for exactly the following cycle.
- Step rate:
  - With a constant `diff_speed = N ≥ 1`, `term` occurs every N cycles.
  - The first `term` falls in the N-th cycle of `run` (cnt = N-1).
  - `step` is high in the cycle after.
- `hit` and `miss` may assert in the same cycle.
- `rst` mid-play has priority over everything and restores the reset values on the next edge.
- Leaving PLAY mid-count: `cnt` is forced to 0 the next cycle, and any pending step is lost.

## Test plan
- Reset, then `mode=PLAY_MODE`, `diff_speed=4`, `level=3`: `step` pulses every 4 cycles, first 5 cycles after entry. The first top row is `lfsr[3:0]=4'h1` from seed 8'h01 (grid bit 0 set), and the LFSR then reads 8'h02.
- `diff_speed=0`: `step` every cycle. Change `diff_speed` 100→3 while `cnt=50`: the next cycle wraps and `step` fires.
- Preload a note to the bottom of lane 2 (run `ROWS` steps, `level=3`). Press lane 2 in a non-term cycle: `hit`=1, bit cleared, `hit_count`+1. Press empty lane 0: no pulse, counts unchanged.
- Press coinciding with the `term` cycle on a bottom note: `hit`=1, `miss`=0 for that lane, `step`=1. A non-pressed bottom note in another lane gives `miss`=1 and `miss_count`+1.
- Force 300 misses (`level=3`, no presses): `miss_count` stops at 255. Leave and re-enter PLAY: `grid`, `hit_count` and `miss_count` read 0 on the second PLAY cycle, and `lfsr` is not reseeded.
- `level=1` (EASY) vs `level=2`: over 64 steps, rows are inserted only when `lfsr[7:6]==3` (respectively `lfsr[7]==1`), checked against a reference LFSR model. Assert `rst` mid-play: all outputs return to their reset values next cycle.

Source files
------------

// File: rtl/note_scroll.sv
// ---------------------------------------------------------------------------
// note_scroll - play-field engine for the guitar game.
//
// Generates falling notes in a LANES x ROWS grid. The grid advances one row
// every i_diff_speed clocks while the game is in PLAY_MODE. Lane presses are
// judged against the bottom (strike) row. Struck notes raise o_hit, and notes
// that fall off the bottom un-struck raise o_miss. Both totals are kept as
// saturating 8-bit counters.
//
// Ports
//   i_clk         system clock
//   i_rst         synchronous active-high reset
//   i_mode[2:0]   current game mode; the field runs when it equals PLAY_MODE
//   i_diff_speed  clocks per row step (0 behaves as 1)
//   i_level[1:0]  1=EASY, 2=MEDIUM, 3=HARD, 0 behaves as EASY
//   i_lane_press  single-cycle press pulses, one per lane
//   o_grid        note bits, bit r*LANES+l = row r, lane l (row 0 is the top)
//   o_step        one-cycle pulse, grid just advanced
//   o_hit         one-cycle pulse, at least one note struck
//   o_miss        one-cycle pulse, at least one note fell off the bottom
//   o_hit_count   saturating hit total
//   o_miss_count  saturating miss total
// ---------------------------------------------------------------------------
module note_scroll #(
    parameter int         LANES     = 4,
    parameter int         ROWS      = 8,
    parameter logic [2:0] PLAY_MODE = 3'd2
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [2:0]             i_mode,
    input  logic [22:0]            i_diff_speed,
    input  logic [1:0]             i_level,
    input  logic [LANES-1:0]       i_lane_press,
    output logic [LANES*ROWS-1:0]  o_grid,
    output logic                   o_step,
    output logic                   o_hit,
    output logic                   o_miss,
    output logic [7:0]             o_hit_count,
    output logic [7:0]             o_miss_count
);

    localparam int GW  = LANES * ROWS;
    localparam int BOT = (ROWS - 1) * LANES;   // LSB of the strike row

    // Adds the number of set bits in v to base, clamping at 255.
    function automatic logic [7:0] sat_add(input logic [7:0] base, input logic [LANES-1:0] v);
        logic [8:0] sum;
        sum = {1'b0, base};
        for (int i = 0; i < LANES; i++) begin
            sum = sum + {8'd0, v[i]};
        end
        return (sum > 9'd255) ? 8'hFF : sum[7:0];
    endfunction

    logic            r_run_d;
    logic [22:0]     r_cnt;
    logic [7:0]      r_lfsr;
    logic [GW-1:0]   r_grid;
    logic            r_step;
    logic            r_hit;
    logic            r_miss;
    logic [7:0]      r_hit_count;
    logic [7:0]      r_miss_count;

    logic            w_run;
    logic            w_entry;
    logic [22:0]     w_eff;
    logic            w_term;
    logic            w_lfsr_fb;
    logic [3:0]      w_row_src;
    logic [LANES-1:0] w_new_row;
    logic [GW-1:0]   w_base_grid;
    logic [GW-1:0]   w_struck;
    logic [GW-1:0]   w_shifted;
    logic [GW-1:0]   w_grid_next;
    logic [LANES-1:0] w_hitv;
    logic [LANES-1:0] w_missv;
    logic [7:0]      w_hit_base;
    logic [7:0]      w_miss_base;

    assign w_run   = (i_mode == PLAY_MODE);
    assign w_entry = w_run & ~r_run_d;
    assign w_eff   = (i_diff_speed == 23'd0) ? 23'd1 : i_diff_speed;
    // ">=" rather than "==" so a speed decrease mid-count wraps immediately.
    assign w_term  = w_run && (r_cnt >= (w_eff - 23'd1));

    assign w_lfsr_fb = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];

    // New top row comes from the LFSR value before it advances.
    always_comb begin
        w_row_src = 4'd0;
        case (i_level)
            2'd3:    w_row_src = r_lfsr[3:0];
            2'd2:    w_row_src = r_lfsr[7] ? r_lfsr[3:0] : 4'd0;
            default: w_row_src = (r_lfsr[7:6] == 2'b11) ? r_lfsr[3:0] : 4'd0;
        endcase
    end
    assign w_new_row = w_row_src[LANES-1:0];

    // On the entry cycle the field starts from an empty grid and zero counts;
    // any advance in that same cycle is applied on top of the cleared state.
    always_comb begin
        w_base_grid = w_entry ? '0 : r_grid;
        w_hitv      = (w_run && !w_entry) ? (i_lane_press & w_base_grid[BOT +: LANES]) : '0;
        w_struck    = w_base_grid;
        w_struck[BOT +: LANES] = w_base_grid[BOT +: LANES] & ~w_hitv;
        // Only notes still present after strike judging can be missed.
        w_missv     = w_term ? w_struck[BOT +: LANES] : '0;
        w_hit_base  = w_entry ? 8'd0 : r_hit_count;
        w_miss_base = w_entry ? 8'd0 : r_miss_count;
    end

    // Row shift: each row moves down one, the new row enters at the top.
    genvar gi;
    generate
        for (gi = 0; gi < ROWS; gi++) begin : g_row
            if (gi == 0) begin : g_top
                assign w_shifted[0 +: LANES] = w_new_row;
            end else begin : g_lower
                assign w_shifted[gi*LANES +: LANES] = w_struck[(gi-1)*LANES +: LANES];
            end
        end
    endgenerate

    assign w_grid_next = w_term ? w_shifted : w_struck;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_run_d      <= 1'b0;
            r_cnt        <= '0;
            r_lfsr       <= 8'h01;
            r_grid       <= '0;
            r_step       <= 1'b0;
            r_hit        <= 1'b0;
            r_miss       <= 1'b0;
            r_hit_count  <= 8'd0;
            r_miss_count <= 8'd0;
        end else begin
            r_run_d <= w_run;
            r_cnt   <= (!w_run || w_term) ? 23'd0 : r_cnt + 23'd1;
            if (w_term) begin
                r_lfsr <= {r_lfsr[6:0], w_lfsr_fb};
            end
            if (w_run) begin
                r_grid       <= w_grid_next;
                r_hit_count  <= sat_add(w_hit_base, w_hitv);
                r_miss_count <= sat_add(w_miss_base, w_missv);
            end
            r_step <= w_term;
            r_hit  <= |w_hitv;
            r_miss <= |w_missv;
        end
    end

    assign o_grid       = r_grid;
    assign o_step       = r_step;
    assign o_hit        = r_hit;
    assign o_miss       = r_miss;
    assign o_hit_count  = r_hit_count;
    assign o_miss_count = r_miss_count;

endmodule

// File: tb/tb_note_scroll.sv
// ---------------------------------------------------------------------------
// tb_note_scroll - self-checking bench for note_scroll.
// A behavioural model (note array, integer counters, integer LFSR) tracks the
// expected play field; a negedge process compares every output each cycle.
// Directed sections add hand-computed literal expectations.
// ---------------------------------------------------------------------------
module tb_note_scroll;

    localparam int LANES = 4;
    localparam int ROWS  = 8;
    localparam int GW    = LANES * ROWS;

    logic            clk;
    logic            rst;
    logic [2:0]      mode;
    logic [22:0]     ds;
    logic [1:0]      level;
    logic [LANES-1:0] press;
    logic [GW-1:0]   o_grid;
    logic            o_step, o_hit, o_miss;
    logic [7:0]      o_hit_count, o_miss_count;

    note_scroll #(.LANES(LANES), .ROWS(ROWS), .PLAY_MODE(3'd2)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_mode       (mode),
        .i_diff_speed (ds),
        .i_level      (level),
        .i_lane_press (press),
        .o_grid       (o_grid),
        .o_step       (o_step),
        .o_hit        (o_hit),
        .o_miss       (o_miss),
        .o_hit_count  (o_hit_count),
        .o_miss_count (o_miss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    // Reference model state
    bit m_note [ROWS][LANES];
    int m_hits, m_misses, m_lfsr, m_phase;
    bit m_prev_run, m_step, m_hit, m_miss;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int min255(input int v);
        return (v > 255) ? 255 : v;
    endfunction

    // Advances the model by one clock, using the inputs present at the edge.
    task automatic model_edge();
        int eff, n, row;
        bit term;
        if (rst) begin
            foreach (m_note[r, l]) m_note[r][l] = 1'b0;
            m_hits = 0; m_misses = 0; m_lfsr = 1; m_phase = 0;
            m_prev_run = 0; m_step = 0; m_hit = 0; m_miss = 0;
            return;
        end
        if (mode != 3'd2) begin
            m_phase = 0; m_prev_run = 0; m_step = 0; m_hit = 0; m_miss = 0;
            return;
        end
        if (!m_prev_run) begin
            foreach (m_note[r, l]) m_note[r][l] = 1'b0;
            m_hits = 0; m_misses = 0;
        end
        n = 0;
        if (m_prev_run) begin
            for (int l = 0; l < LANES; l++) begin
                if (press[l] && m_note[ROWS-1][l]) begin
                    m_note[ROWS-1][l] = 1'b0;
                    n++;
                end
            end
        end
        m_hit  = (n > 0);
        m_hits = min255(m_hits + n);
        eff  = (ds == 0) ? 1 : int'(ds);
        term = (m_phase + 1 >= eff);
        m_step = term;
        m_miss = 0;
        if (term) begin
            n = 0;
            for (int l = 0; l < LANES; l++) if (m_note[ROWS-1][l]) n++;
            m_miss   = (n > 0);
            m_misses = min255(m_misses + n);
            for (int r = ROWS - 1; r > 0; r--)
                for (int l = 0; l < LANES; l++) m_note[r][l] = m_note[r-1][l];
            if (level == 2'd3)                      row = m_lfsr % 16;
            else if (level == 2'd2)                 row = (m_lfsr >= 128) ? m_lfsr % 16 : 0;
            else                                    row = (m_lfsr / 64 == 3) ? m_lfsr % 16 : 0;
            for (int l = 0; l < LANES; l++) m_note[0][l] = ((row >> l) & 1) == 1;
            // Taps 7,5,4,3 shifted into bit 0.
            n = ((m_lfsr >> 7) ^ (m_lfsr >> 5) ^ (m_lfsr >> 4) ^ (m_lfsr >> 3)) & 1;
            m_lfsr  = ((m_lfsr * 2) % 256) + n;
            m_phase = 0;
        end else begin
            m_phase++;
        end
        m_prev_run = 1;
    endtask

    // One clock: inputs already set, press held for this cycle only.
    task automatic cyc(input logic [LANES-1:0] p);
        press = p;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        press = '0;
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin : compare
        logic [GW-1:0] eg;
        if (chk_en) begin
            eg = '0;
            for (int r = 0; r < ROWS; r++)
                for (int l = 0; l < LANES; l++) eg[r*LANES+l] = m_note[r][l];
            chk("grid",       o_grid,       eg);
            chk("step",       {31'd0, o_step}, {31'd0, m_step});
            chk("hit",        {31'd0, o_hit},  {31'd0, m_hit});
            chk("miss",       {31'd0, o_miss}, {31'd0, m_miss});
            chk("hit_count",  {24'd0, o_hit_count},  m_hits);
            chk("miss_count", {24'd0, o_miss_count}, m_misses);
        end
    end

    initial begin
        rst = 1'b1; mode = 3'd0; ds = 23'd4; level = 2'd3; press = '0;
        @(negedge clk);
        cyc('0);
        chk_en = 1'b1;
        cyc('0);
        $display("reset: grid=%h step=%b hit=%b miss=%b", o_grid, o_step, o_hit, o_miss);
        chk("rst_grid", o_grid, 32'h0);
        chk("rst_counts", {16'd0, o_hit_count, o_miss_count}, 32'h0);
        rst = 1'b0;

        // First song: HARD, speed 4. Steps at the 4th, 8th ... cycle of PLAY.
        mode = 3'd2;
        repeat (3) cyc('0);
        chk("first_step_early", {31'd0, o_step}, 32'd0);
        cyc('0);
        $display("first step: step=%b grid=%h", o_step, o_grid);
        chk("first_step", {31'd0, o_step}, 32'd1);
        chk("first_row", o_grid, 32'h1);
        chk("model_lfsr_after_1", m_lfsr, 32'h02);
        repeat (28) cyc('0);
        $display("after 8 steps: grid=%h", o_grid);
        chk("grid_8_steps", o_grid, 32'h1248_137E);
        cyc(4'b0001);                       // non-term press on bottom lane 0
        $display("press lane0: hit=%b hit_count=%0d grid=%h", o_hit, o_hit_count, o_grid);
        chk("hit_lane0", {31'd0, o_hit}, 32'd1);
        chk("hit_count_1", {24'd0, o_hit_count}, 32'd1);
        chk("cleared_lane0", o_grid, 32'h0248_137E);
        cyc(4'b0001);                       // lane 0 is now empty
        $display("press empty lane0: hit=%b hit_count=%0d", o_hit, o_hit_count);
        chk("empty_press_hit", {31'd0, o_hit}, 32'd0);
        chk("empty_press_count", {24'd0, o_hit_count}, 32'd1);
        repeat (2) cyc('0);                 // term at cycle 36, bottom was empty
        chk("step_no_miss", {30'd0, o_step, o_miss}, 32'b10);
        repeat (3) cyc('0);
        cyc(4'b0010);                       // press coincides with term, lane 1
        $display("press on term: step=%b hit=%b miss=%b", o_step, o_hit, o_miss);
        chk("term_press", {29'd0, o_step, o_hit, o_miss}, 32'b110);
        chk("hit_count_2", {24'd0, o_hit_count}, 32'd2);
        repeat (4) cyc('0);                 // lane 2 note leaves un-struck
        chk("miss_lane2", {31'd0, o_miss}, 32'd1);
        chk("miss_count_1", {24'd0, o_miss_count}, 32'd1);
        repeat (11) cyc('0);
        cyc(4'b0001);                       // bottom 0x3: lane 0 hit, lane 1 missed
        $display("hit+miss: hit=%b miss=%b hc=%0d mc=%0d", o_hit, o_miss, o_hit_count, o_miss_count);
        chk("hit_and_miss", {30'd0, o_hit, o_miss}, 32'b11);
        chk("counts_3_4", {16'd0, o_hit_count, o_miss_count}, 32'h0304);

        // Speed change 100 -> 3 with cnt at 50 wraps on the next cycle.
        mode = 3'd0; cyc('0);
        mode = 3'd2; ds = 23'd100;
        repeat (50) cyc('0);
        chk("slow_no_step", {31'd0, o_step}, 32'd0);
        ds = 23'd3;
        cyc('0);
        $display("speed drop: step=%b", o_step);
        chk("speed_drop_step", {31'd0, o_step}, 32'd1);

        // diff_speed 0: step every cycle.
        ds = 23'd0;
        for (int i = 0; i < 5; i++) begin
            cyc('0);
            chk("speed0_step", {31'd0, o_step}, 32'd1);
        end

        // Saturating miss count.
        mode = 3'd0; cyc('0);
        mode = 3'd2; ds = 23'd1; level = 2'd3;
        repeat (400) cyc('0);
        $display("saturation: miss_count=%0d", o_miss_count);
        chk("miss_sat", {24'd0, o_miss_count}, 32'd255);

        // Leave and re-enter: field cleared by the second PLAY cycle.
        mode = 3'd0; cyc('0);
        mode = 3'd2; ds = 23'd4;
        cyc(4'b1111); cyc('0);
        $display("re-entry: grid=%h hc=%0d mc=%0d", o_grid, o_hit_count, o_miss_count);
        chk("reentry_grid", o_grid, 32'h0);
        chk("reentry_counts", {16'd0, o_hit_count, o_miss_count}, 32'h0);

        // Randomized play: levels, speeds, presses, mode exits, rare resets.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 63) == 0) level = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 99) == 0) ds = 23'($urandom_range(0, 6));
            if ($urandom_range(0, 149) == 0) mode = 3'($urandom_range(0, 7));
            else if (mode != 3'd2 && $urandom_range(0, 3) == 0) mode = 3'd2;
            rst = ($urandom_range(0, 499) == 0);
            cyc(($urandom_range(0, 2) == 0) ? LANES'($urandom) : '0);
        end
        rst = 1'b0;

        // Reset mid-play restores reset values on the next edge.
        mode = 3'd2; ds = 23'd1; level = 2'd3;
        repeat (20) cyc('0);
        rst = 1'b1;
        cyc(4'b1111);
        $display("mid-play reset: grid=%h step=%b hc=%0d mc=%0d", o_grid, o_step, o_hit_count, o_miss_count);
        chk("midrst_grid", o_grid, 32'h0);
        chk("midrst_pulses", {29'd0, o_step, o_hit, o_miss}, 32'd0);
        chk("midrst_counts", {16'd0, o_hit_count, o_miss_count}, 32'h0);
        rst = 1'b0;
        cyc('0);

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
